// File: rtl/cam_pixel_capture_if.sv
// Camera byte bus in, assembled RGB565 pixel stream out.
interface cam_pixel_capture_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              vsync;
    logic              href;
    logic [7:0]        cam_d;
    logic [15:0]       pixel_data;
    logic              pixel_valid;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        x;
    logic [6:0]        y;
    logic              frame_done;
    logic              err;

    modport master (
        output vsync, href, cam_d,
        input  pixel_data, pixel_valid, addr, x, y, frame_done, err
    );

    modport slave (
        input  vsync, href, cam_d,
        output pixel_data, pixel_valid, addr, x, y, frame_done, err
    );
endinterface

// File: rtl/cam_pixel_capture.sv
// Samples the 8-bit camera bus, pairs bytes into RGB565 pixels and tags each
// accepted pixel with its column, row and linear framebuffer address.
module cam_pixel_capture #(
    parameter int unsigned H_PIXELS = 160,
    parameter int unsigned V_LINES  = 120,
    parameter int unsigned ADDR_W   = 15
) (
    input logic                p_clock,
    input logic                rst_n,
    cam_pixel_capture_if.slave bus
);
    localparam int unsigned COL_W = 8;
    localparam int unsigned ROW_W = 7;

    typedef enum logic [1:0] {S_SYNC, S_VBLANK, S_ACTIVE} state_t;

    state_t            state;
    logic              r_vsync;
    logic              r_href;
    logic              r_href_prev;
    logic [7:0]        r_d;
    logic [7:0]        hi_byte;
    logic              phase;
    logic              line_acc;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr_cnt;

    logic [15:0]       pixel_data_q;
    logic              pixel_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [COL_W-1:0]  x_q;
    logic [ROW_W-1:0]  y_q;
    logic              frame_done_q;
    logic              err_q;

    // Single register stage on the camera pins; r_href_prev detects line end.
    always_ff @(posedge p_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_href_prev <= 1'b0;
            r_d         <= '0;
        end else begin
            r_vsync     <= bus.vsync;
            r_href      <= bus.href;
            r_href_prev <= r_href;
            r_d         <= bus.cam_d;
        end
    end

    // Frame FSM, byte pairing and pixel presentation.
    always_ff @(posedge p_clock or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_SYNC;
            hi_byte       <= '0;
            phase         <= 1'b0;
            line_acc      <= 1'b0;
            col           <= '0;
            row           <= '0;
            addr_cnt      <= '0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            addr_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            case (state)
                S_SYNC: begin
                    if (r_vsync) state <= S_VBLANK;
                end
                S_VBLANK: begin
                    if (!r_vsync) begin
                        col      <= '0;
                        row      <= '0;
                        addr_cnt <= '0;
                        phase    <= 1'b0;
                        line_acc <= 1'b0;
                        state    <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    // A vsync rise takes priority over any byte in the same cycle.
                    if (r_vsync) begin
                        frame_done_q <= 1'b1;
                        phase        <= 1'b0;
                        state        <= S_VBLANK;
                    end else if (r_href) begin
                        phase <= ~phase;
                        if (!phase) begin
                            hi_byte <= r_d;
                        end else begin
                            if (col < COL_W'(H_PIXELS) && row < ROW_W'(V_LINES)) begin
                                pixel_data_q  <= {hi_byte, r_d};
                                pixel_valid_q <= 1'b1;
                                x_q           <= col;
                                y_q           <= row;
                                addr_q        <= addr_cnt;
                                col           <= col + COL_W'(1);
                                addr_cnt      <= addr_cnt + ADDR_W'(1);
                                line_acc      <= 1'b1;
                            end
                            if (col >= COL_W'(H_PIXELS)) err_q <= 1'b1;
                        end
                    end else if (r_href_prev) begin
                        // Line end: a dangling first byte means an odd byte count.
                        if (phase) err_q <= 1'b1;
                        phase    <= 1'b0;
                        col      <= '0;
                        line_acc <= 1'b0;
                        if (line_acc && row < ROW_W'(V_LINES)) row <= row + ROW_W'(1);
                    end
                end
                default: state <= S_SYNC;
            endcase
        end
    end

    assign bus.pixel_data  = pixel_data_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.addr        = addr_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench: a 2x2 instance for directed corner cases and a default
// 160x120 instance for a full oversized frame.
module tb_cam_pixel_capture;
    typedef struct packed {
        logic [15:0] pix;
        logic [14:0] addr;
        logic [7:0]  x;
        logic [6:0]  y;
    } pix_t;

    logic       p_clock = 1'b0;
    logic       rst_n   = 1'b1;
    logic       vs [2];
    logic       hr [2];
    logic [7:0] dd [2];

    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   fd_cnt_s = 0;
    int   fd_cnt_l = 0;
    int   fd_exp_s = 0;
    int   n_pix_l  = 0;
    logic [14:0] last_addr_l = '0;
    logic prev_v_s = 1'b0;
    logic prev_v_l = 1'b0;
    pix_t q_s[$];
    pix_t q_l[$];
    pix_t got_s, exp_s, got_l, exp_l;

    cam_pixel_capture_if #(.ADDR_W(15)) bus_s ();
    cam_pixel_capture_if #(.ADDR_W(15)) bus_l ();

    assign bus_s.vsync = vs[0];
    assign bus_s.href  = hr[0];
    assign bus_s.cam_d = dd[0];
    assign bus_l.vsync = vs[1];
    assign bus_l.href  = hr[1];
    assign bus_l.cam_d = dd[1];

    cam_pixel_capture #(.H_PIXELS(2), .V_LINES(2), .ADDR_W(15)) dut_s (
        .p_clock (p_clock),
        .rst_n   (rst_n),
        .bus     (bus_s)
    );

    cam_pixel_capture #(.H_PIXELS(160), .V_LINES(120), .ADDR_W(15)) dut_l (
        .p_clock (p_clock),
        .rst_n   (rst_n),
        .bus     (bus_l)
    );

    always #5 p_clock = ~p_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic pix_t mk(input logic [15:0] p, input int a, input int xx, input int yy);
        mk = '{pix: p, addr: 15'(a), x: 8'(xx), y: 7'(yy)};
    endfunction

    // Each driver call sets pins just after a negedge and returns at the next one.
    task automatic drive(input int i, input logic v, input logic h, input logic [7:0] b);
        vs[i] = v;
        hr[i] = h;
        dd[i] = b;
        @(negedge p_clock);
    endtask

    task automatic idle(input int i, input int n);
        repeat (n) drive(i, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic vhigh(input int i, input int n);
        repeat (n) drive(i, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic vsync_pulse(input int i);
        vhigh(i, 3);
        idle(i, 3);
    endtask

    task automatic send_line(input int i, input logic [63:0] b, input int n);
        for (int k = 0; k < n; k++) drive(i, 1'b0, 1'b1, b[8*(n-1-k) +: 8]);
        idle(i, 3);
    endtask

    // Monitor for the 2x2 instance.
    always @(negedge p_clock) begin
        if (bus_s.pixel_valid) begin
            got_s = {bus_s.pixel_data, bus_s.addr, bus_s.x, bus_s.y};
            check("s_pixel_spacing", 32'(prev_v_s), 32'd0);
            if (q_s.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL s_unexpected_pixel: got data=%h addr=%0d x=%0d y=%0d, required no pulse",
                         got_s.pix, got_s.addr, got_s.x, got_s.y);
            end else begin
                exp_s = q_s.pop_front();
                n_cmp++;
                if (got_s !== exp_s) begin
                    n_bad++;
                    $display("FAIL s_pixel: got data=%h addr=%0d x=%0d y=%0d, required data=%h addr=%0d x=%0d y=%0d",
                             got_s.pix, got_s.addr, got_s.x, got_s.y, exp_s.pix, exp_s.addr, exp_s.x, exp_s.y);
                end
            end
        end
        if (bus_s.frame_done) fd_cnt_s++;
        prev_v_s = bus_s.pixel_valid;
    end

    // Monitor for the full-size instance.
    always @(negedge p_clock) begin
        if (bus_l.pixel_valid) begin
            got_l = {bus_l.pixel_data, bus_l.addr, bus_l.x, bus_l.y};
            n_pix_l++;
            last_addr_l = bus_l.addr;
            if (q_l.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL l_unexpected_pixel: got data=%h addr=%0d, required no pulse",
                         got_l.pix, got_l.addr);
            end else begin
                exp_l = q_l.pop_front();
                n_cmp++;
                if (got_l !== exp_l) begin
                    n_bad++;
                    $display("FAIL l_pixel: got data=%h addr=%0d x=%0d y=%0d, required data=%h addr=%0d x=%0d y=%0d",
                             got_l.pix, got_l.addr, got_l.x, got_l.y, exp_l.pix, exp_l.addr, exp_l.x, exp_l.y);
                end
            end
        end
        if (bus_l.frame_done) fd_cnt_l++;
        prev_v_l = bus_l.pixel_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            vs[i] = 1'b0;
            hr[i] = 1'b0;
            dd[i] = 8'h00;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge p_clock);
        check("rst_pixel_data",  32'(bus_s.pixel_data),  32'd0);
        check("rst_pixel_valid", 32'(bus_s.pixel_valid), 32'd0);
        check("rst_addr",        32'(bus_s.addr),        32'd0);
        check("rst_x",           32'(bus_s.x),           32'd0);
        check("rst_y",           32'(bus_s.y),           32'd0);
        check("rst_frame_done",  32'(bus_s.frame_done),  32'd0);
        check("rst_err",         32'(bus_s.err),         32'd0);
        rst_n = 1'b1;

        // Basic 2x2 frame.
        vsync_pulse(0);
        q_s.push_back(mk(16'hA1B2, 0, 0, 0));
        q_s.push_back(mk(16'hC3D4, 1, 1, 0));
        send_line(0, 64'hA1B2C3D4, 4);
        q_s.push_back(mk(16'hE5F6, 2, 0, 1));
        q_s.push_back(mk(16'h0718, 3, 1, 1));
        send_line(0, 64'hE5F60718, 4);
        vs[0] = 1'b1;
        @(negedge p_clock);
        check("t1_frame_done_early", 32'(bus_s.frame_done), 32'd0);
        @(negedge p_clock);
        check("t1_frame_done_pulse", 32'(bus_s.frame_done), 32'd1);
        @(negedge p_clock);
        check("t1_frame_done_end",   32'(bus_s.frame_done), 32'd0);
        check("t1_err_clean",        32'(bus_s.err),        32'd0);
        fd_exp_s++;
        vhigh(0, 2);

        // Release reset mid-frame: nothing until a full vsync high->low.
        rst_n = 1'b0;
        idle(0, 2);
        rst_n = 1'b1;
        send_line(0, 64'h0102030405060708, 6);
        send_line(0, 64'h1112131415161718, 8);
        vsync_pulse(0);
        q_s.push_back(mk(16'h5AA5, 0, 0, 0));
        send_line(0, 64'h5AA5, 2);
        vsync_pulse(0);
        fd_exp_s++;

        // Odd byte count, then a clean line.
        check("t3_err_before", 32'(bus_s.err), 32'd0);
        q_s.push_back(mk(16'h1122, 0, 0, 0));
        q_s.push_back(mk(16'h3344, 1, 1, 0));
        send_line(0, 64'h1122334455, 5);
        check("t3_err_odd", 32'(bus_s.err), 32'd1);
        q_s.push_back(mk(16'h6677, 2, 0, 1));
        q_s.push_back(mk(16'h8899, 3, 1, 1));
        send_line(0, 64'h66778899, 4);
        vsync_pulse(0);
        fd_exp_s++;

        // Overlong line: extra pixel dropped, address stays bounded.
        rst_n = 1'b0;
        idle(0, 1);
        check("t4_err_reset", 32'(bus_s.err), 32'd0);
        idle(0, 1);
        rst_n = 1'b1;
        vsync_pulse(0);
        q_s.push_back(mk(16'h0102, 0, 0, 0));
        q_s.push_back(mk(16'h0304, 1, 1, 0));
        send_line(0, 64'h010203040506, 6);
        check("t4_err_overrun", 32'(bus_s.err), 32'd1);
        q_s.push_back(mk(16'h0708, 2, 0, 1));
        send_line(0, 64'h0708, 2);
        vsync_pulse(0);
        fd_exp_s++;

        // Reset asserted while the second byte of a pixel is on the pins.
        rst_n = 1'b0;
        idle(0, 1);
        rst_n = 1'b1;
        vsync_pulse(0);
        q_s.push_back(mk(16'hABCD, 0, 0, 0));
        drive(0, 1'b0, 1'b1, 8'hAB);
        drive(0, 1'b0, 1'b1, 8'hCD);
        drive(0, 1'b0, 1'b1, 8'hEF);
        hr[0] = 1'b1;
        dd[0] = 8'h12;
        rst_n = 1'b0;
        #1;
        check("t5_pixel_data", 32'(bus_s.pixel_data),  32'd0);
        check("t5_valid",      32'(bus_s.pixel_valid), 32'd0);
        check("t5_addr",       32'(bus_s.addr),        32'd0);
        check("t5_err",        32'(bus_s.err),         32'd0);
        @(negedge p_clock);
        drive(0, 1'b0, 1'b1, 8'h34);
        drive(0, 1'b0, 1'b1, 8'h56);
        rst_n = 1'b1;
        send_line(0, 64'h789ABCDE, 4);
        vsync_pulse(0);
        q_s.push_back(mk(16'h3CC3, 0, 0, 0));
        send_line(0, 64'h3CC3, 2);
        vhigh(0, 4);
        fd_exp_s++;
        idle(0, 2);

        // Full-size frame with two surplus lines.
        vsync_pulse(1);
        for (int r = 0; r < 122; r++) begin
            for (int c = 0; c < 160; c++) begin
                if (r < 120) q_l.push_back(mk({8'(r), 8'(c)}, r * 160 + c, c, r));
                drive(1, 1'b0, 1'b1, 8'(r));
                drive(1, 1'b0, 1'b1, 8'(c));
            end
            idle(1, 3);
        end
        vhigh(1, 4);
        idle(1, 4);

        check("s_queue_drained",  32'(q_s.size()),  32'd0);
        check("s_frame_done_cnt", 32'(fd_cnt_s),    32'(fd_exp_s));
        check("l_queue_drained",  32'(q_l.size()),  32'd0);
        check("l_pixel_count",    32'(n_pix_l),     32'd19200);
        check("l_last_addr",      32'(last_addr_l), 32'd19199);
        check("l_err_clean",      32'(bus_l.err),   32'd0);
        check("l_frame_done_cnt", 32'(fd_cnt_l),    32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
